// File: rtl/pkt_prior_sched_pkg.sv
// Shared packet definitions for the priority-queue scheduler slice.
//   PRIOR_WIDTH   : width of the priority field carried in every header
//   pkHeadInfo    : packet header presented by each ingress requester
//   sched_state_e : scheduler phase (FILL / DRAIN / WAIT)
package pkt_h;

  localparam int PRIOR_WIDTH = 8;

  typedef struct packed {
    logic [7:0]             src;
    logic [15:0]            len;
    logic [PRIOR_WIDTH-1:0] prior;
  } pkHeadInfo;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    WAIT  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/pkt_prior_sched_if.sv
// Bus bundle between pkt_prior_sched and its surroundings.
//   ingress : req_valid / req_ready / req_info / req_data (one lane per requester)
//   enqueue : pq_en / pq_ready / pq_info / pq_data
//   dequeue : pq_deq_en / pq_out_valid / pq_out_data / pq_out_prior
//   egress  : eg_valid / eg_ready / eg_data / eg_prior
//   status  : grant_id / drain_active
// modport master = scheduler view, modport slave = environment view.
interface pkt_prior_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 64
);
  import pkt_h::*;

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  pkHeadInfo [NUM_REQ-1:0]        req_info;
  logic [NUM_REQ-1:0][DWIDTH-1:0] req_data;

  logic                           pq_en;
  logic                           pq_ready;
  pkHeadInfo                      pq_info;
  logic [DWIDTH-1:0]              pq_data;

  logic                           pq_deq_en;
  logic                           pq_out_valid;
  logic [DWIDTH-1:0]              pq_out_data;
  logic [PRIOR_WIDTH-1:0]         pq_out_prior;

  logic                           eg_valid;
  logic                           eg_ready;
  logic [DWIDTH-1:0]              eg_data;
  logic [PRIOR_WIDTH-1:0]         eg_prior;

  logic [IW-1:0]                  grant_id;
  logic                           drain_active;

  modport master (
    input  req_valid, req_info, req_data, pq_ready,
           pq_out_valid, pq_out_data, pq_out_prior, eg_ready,
    output req_ready, pq_en, pq_info, pq_data, pq_deq_en,
           eg_valid, eg_data, eg_prior, grant_id, drain_active
  );

  modport slave (
    output req_valid, req_info, req_data, pq_ready,
           pq_out_valid, pq_out_data, pq_out_prior, eg_ready,
    input  req_ready, pq_en, pq_info, pq_data, pq_deq_en,
           eg_valid, eg_data, eg_prior, grant_id, drain_active
  );

endinterface

// File: rtl/pkt_prior_sched_arb.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : highest-priority index this cycle
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the granted requester
// The first set request at or after ptr, wrapping past NUM_REQ-1, wins.
module pkt_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);

  logic          found;
  logic [IW:0]   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // one extra bit so ptr+i never overflows before the wrap
      idx = {1'b0, ptr} + (IW+1)'(i);
      if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
      if (!found && req[idx[IW-1:0]]) begin
        found                = 1'b1;
        gnt[idx[IW-1:0]]     = 1'b1;
        gnt_idx              = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/pkt_prior_sched.sv
// Scheduler wrapped around the pkt_Priorer priority queue.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : pkt_prior_sched_if.master (ingress, enqueue, dequeue, egress, status)
// FILL  : round-robin ingress onto the enqueue port (registered, held until pq_ready).
// DRAIN : issue single-cycle dequeues, at most DRAIN_BATCH per phase.
// WAIT  : wait for the queue's output and load it into the egress register.
module pkt_prior_sched #(
  parameter int NUM_REQ      = 4,
  parameter int DWIDTH       = 64,
  parameter int QDEPTH       = 16,
  parameter int DRAIN_BATCH  = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  pkt_prior_sched_if.master  bus
);
  import pkt_h::*;

  localparam int IW = $clog2(NUM_REQ);
  localparam int OW = $clog2(QDEPTH+1);
  localparam int BW = $clog2(DRAIN_BATCH+1);
  localparam int TW = $clog2(IDLE_TIMEOUT+1);

  sched_state_e           state, state_nxt;
  logic [OW-1:0]          occ;
  logic [BW-1:0]          batch_cnt;
  logic [TW-1:0]          idle_cnt;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          grant_id;

  logic                   pq_en;
  pkHeadInfo              pq_info;
  logic [DWIDTH-1:0]      pq_data;

  logic                   eg_valid;
  logic [DWIDTH-1:0]      eg_data;
  logic [PRIOR_WIDTH-1:0] eg_prior;

  logic [NUM_REQ-1:0]     gnt, req_ready;
  logic [IW-1:0]          gnt_idx;

  logic in_fill, full, occ_nz, enq_open, enq_hs, enq_xfer;
  logic idle_hit, batch_done, drain_done, eg_free, go_drain, deq, capture;

  pkt_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign in_fill    = (state == FILL);
  assign full       = (occ == OW'(QDEPTH));
  assign occ_nz     = (occ != '0);
  // the payload register may be refilled when empty or emptying this cycle
  assign enq_open   = in_fill & (!pq_en | bus.pq_ready) & !full;
  assign req_ready  = enq_open ? gnt : '0;
  assign enq_hs     = |(bus.req_valid & req_ready);
  assign enq_xfer   = pq_en & bus.pq_ready;

  assign idle_hit   = (idle_cnt == TW'(IDLE_TIMEOUT));
  assign batch_done = (batch_cnt == BW'(DRAIN_BATCH));
  assign drain_done = batch_done | !occ_nz;
  assign eg_free    = !eg_valid | bus.eg_ready;

  // never switch phase with an enqueue still in flight
  assign go_drain   = in_fill & !pq_en &
                      (full | (!bus.pq_ready & occ_nz) | (idle_hit & occ_nz));
  assign deq        = (state == DRAIN) & !drain_done & eg_free;
  // queue output outside WAIT is ignored
  assign capture    = (state == WAIT) & bus.pq_out_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (go_drain) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = FILL;
               else if (deq)   state_nxt = WAIT;
      WAIT:    if (capture) state_nxt = drain_done ? FILL : DRAIN;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      occ       <= '0;
      batch_cnt <= '0;
      idle_cnt  <= '0;
      rr_ptr    <= '0;
      grant_id  <= '0;
      pq_en     <= 1'b0;
      pq_info   <= '0;
      pq_data   <= '0;
      eg_valid  <= 1'b0;
      eg_data   <= '0;
      eg_prior  <= '0;
    end else begin
      state <= state_nxt;

      if (enq_hs) begin
        pq_en    <= 1'b1;
        pq_info  <= bus.req_info[gnt_idx];
        pq_data  <= bus.req_data[gnt_idx];
        grant_id <= gnt_idx;
        rr_ptr   <= (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end else if (enq_xfer) begin
        pq_en <= 1'b0;
      end

      case ({enq_xfer, deq})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      if (go_drain)  batch_cnt <= '0;
      else if (deq)  batch_cnt <= batch_cnt + 1'b1;

      // saturating count of request-free FILL cycles
      if (!in_fill || (|bus.req_valid)) idle_cnt <= '0;
      else if (!idle_hit)              idle_cnt <= idle_cnt + 1'b1;

      if (capture) begin
        eg_valid <= 1'b1;
        eg_data  <= bus.pq_out_data;
        eg_prior <= bus.pq_out_prior;
      end else if (bus.eg_ready) begin
        eg_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.pq_en        = pq_en;
  assign bus.pq_info      = pq_info;
  assign bus.pq_data      = pq_data;
  assign bus.pq_deq_en    = deq;
  assign bus.eg_valid     = eg_valid;
  assign bus.eg_data      = eg_data;
  assign bus.eg_prior     = eg_prior;
  assign bus.grant_id     = grant_id;
  assign bus.drain_active = (state != FILL);

endmodule

// File: tb/tb_pkt_prior_sched.sv
// Directed bench for pkt_prior_sched with a small FIFO stand-in for the queue.
module tb_pkt_prior_sched;
  import pkt_h::*;

  localparam int NR = 4;
  localparam int DW = 64;

  logic clk, rst;
  int   total  = 0;
  int   passed = 0;

  int exp_gid [5] = '{0, 1, 2, 3, 0};
  int exp_pri [3] = '{5, 9, 2};
  int exp_dat [3] = '{'h55, 'h99, 'h22};

  pkt_prior_sched_if #(.NUM_REQ(NR), .DWIDTH(DW)) bus();

  pkt_prior_sched #(
    .NUM_REQ(NR), .DWIDTH(DW), .QDEPTH(16), .DRAIN_BATCH(8), .IDLE_TIMEOUT(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // queue stand-in: FIFO order, output valid one cycle after a dequeue pulse
  typedef struct {
    logic [DW-1:0]          d;
    logic [PRIOR_WIDTH-1:0] p;
  } ent_t;
  ent_t q[$];

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      bus.pq_out_valid <= 1'b0;
      bus.pq_out_data  <= '0;
      bus.pq_out_prior <= '0;
    end else begin
      bus.pq_out_valid <= 1'b0;
      if (bus.pq_deq_en && q.size() > 0) begin
        bus.pq_out_valid <= 1'b1;
        bus.pq_out_data  <= q[0].d;
        bus.pq_out_prior <= q[0].p;
        void'(q.pop_front());
      end
      if (bus.pq_en && bus.pq_ready) q.push_back('{bus.pq_data, bus.pq_info.prior});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_info  = '0;
    bus.req_data  = '0;
    bus.pq_ready  = 1'b1;
    bus.eg_ready  = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    check({tag, "_pq_en"},     64'(bus.pq_en), 64'd0);
    check({tag, "_pq_info"},   64'(bus.pq_info), 64'd0);
    check({tag, "_pq_data"},   bus.pq_data, 64'd0);
    check({tag, "_pq_deq_en"}, 64'(bus.pq_deq_en), 64'd0);
    check({tag, "_eg_valid"},  64'(bus.eg_valid), 64'd0);
    check({tag, "_eg_data"},   bus.eg_data, 64'd0);
    check({tag, "_eg_prior"},  64'(bus.eg_prior), 64'd0);
    check({tag, "_grant_id"},  64'(bus.grant_id), 64'd0);
    check({tag, "_drain"},     64'(bus.drain_active), 64'd0);
    check({tag, "_state"},     64'(dut.state), 64'(FILL));
    check({tag, "_occ"},       64'(dut.occ), 64'd0);
  endtask

  initial begin
    int n;
    int beats;

    // ---- reset values
    do_reset();
    check_zero("rst");

    // ---- round robin: all four requesting, queue always ready
    for (int i = 0; i < NR; i++) begin
      bus.req_info[i].prior = 8'(8'h10 + i);
      bus.req_data[i]       = 64'(64'hA0 + i);
    end
    bus.req_valid = 4'hF;
    #1;
    check("rr_first_ready", 64'(bus.req_ready), 64'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_gid",  64'(bus.grant_id), 64'(exp_gid[k]));
      check("rr_pq_en", 64'(bus.pq_en), 64'd1);
      check("rr_pq_data", bus.pq_data, 64'(64'hA0 + exp_gid[k]));
    end
    bus.req_valid = '0;
    tick();
    check("rr_pq_en_off", 64'(bus.pq_en), 64'd0);
    check("rr_occ", 64'(dut.occ), 64'd5);

    // ---- back-pressure with an enqueue pending at occupancy 3
    do_reset();
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      bus.req_data[0] = 64'(100 + k);
      tick();
    end
    bus.pq_ready    = 1'b0;
    bus.req_data[0] = 64'hDEAD;
    #1;
    check("bp_req_ready", 64'(bus.req_ready), 64'd0);
    check("bp_occ", 64'(dut.occ), 64'd3);
    repeat (3) tick();
    check("bp_pq_en_held", 64'(bus.pq_en), 64'd1);
    check("bp_pq_data_held", bus.pq_data, 64'd103);
    check("bp_state_fill", 64'(dut.state), 64'(FILL));
    bus.req_valid = '0;
    bus.pq_ready  = 1'b1;
    tick();
    bus.pq_ready = 1'b0;
    check("bp_pq_en_clear", 64'(bus.pq_en), 64'd0);
    check("bp_occ4", 64'(dut.occ), 64'd4);
    tick();
    check("bp_state_drain", 64'(dut.state), 64'(DRAIN));
    check("bp_drain_active", 64'(bus.drain_active), 64'd1);
    check("bp_deq", 64'(bus.pq_deq_en), 64'd1);

    // ---- full queue: 16 enqueues then one DRAIN batch of 8
    do_reset();
    bus.req_valid = 4'hF;
    repeat (16) tick();
    bus.req_valid = '0;
    tick();
    check("full_occ", 64'(dut.occ), 64'd16);
    tick();
    check("full_state_drain", 64'(dut.state), 64'(DRAIN));
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.pq_deq_en) n++;
      if (dut.state == FILL) break;
      tick();
    end
    check("full_deq_count", 64'(n), 64'd8);
    check("full_back_fill", 64'(dut.state), 64'(FILL));
    check("full_occ_after", 64'(dut.occ), 64'd8);

    // ---- idle timeout drain of three entries
    do_reset();
    bus.req_valid         = 4'b0100;
    bus.req_info[2].prior = 8'd5;  bus.req_data[2] = 64'h55;
    tick();
    bus.req_info[2].prior = 8'd9;  bus.req_data[2] = 64'h99;
    tick();
    bus.req_info[2].prior = 8'd2;  bus.req_data[2] = 64'h22;
    tick();
    bus.req_valid = '0;
    repeat (16) tick();
    check("idle_still_fill", 64'(dut.state), 64'(FILL));
    check("idle_occ3", 64'(dut.occ), 64'd3);
    tick();
    check("idle_drain", 64'(dut.state), 64'(DRAIN));
    beats = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.eg_valid) begin
        check("idle_eg_prior", 64'(bus.eg_prior), 64'(exp_pri[beats]));
        check("idle_eg_data", bus.eg_data, 64'(exp_dat[beats]));
        beats++;
      end
      if (beats == 3) break;
      tick();
    end
    check("idle_beats", 64'(beats), 64'd3);
    check("idle_end_fill", 64'(dut.state), 64'(FILL));
    check("idle_end_occ", 64'(dut.occ), 64'd0);

    // ---- egress stall holds one beat and blocks further dequeues
    do_reset();
    bus.eg_ready          = 1'b0;
    bus.req_valid         = 4'b0001;
    bus.req_info[0].prior = 8'd7;  bus.req_data[0] = 64'h77;
    tick();
    bus.req_info[0].prior = 8'd3;  bus.req_data[0] = 64'h33;
    tick();
    bus.req_valid = '0;
    tick();
    bus.pq_ready = 1'b0;
    tick();
    check("st_state_drain", 64'(dut.state), 64'(DRAIN));
    check("st_first_deq", 64'(bus.pq_deq_en), 64'd1);
    repeat (2) tick();
    check("st_eg_valid", 64'(bus.eg_valid), 64'd1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.pq_deq_en) n++;
      tick();
    end
    check("st_no_deq", 64'(n), 64'd0);
    check("st_eg_held", 64'(bus.eg_valid), 64'd1);
    check("st_eg_prior", 64'(bus.eg_prior), 64'd7);
    check("st_eg_data", bus.eg_data, 64'h77);
    bus.eg_ready = 1'b1;
    #1;
    check("st_deq_resume", 64'(bus.pq_deq_en), 64'd1);
    repeat (2) tick();
    check("st_eg2_valid", 64'(bus.eg_valid), 64'd1);
    check("st_eg2_prior", 64'(bus.eg_prior), 64'd3);
    check("st_end_fill", 64'(dut.state), 64'(FILL));

    // ---- reset one cycle after a dequeue pulse
    do_reset();
    bus.req_valid         = 4'b0001;
    bus.req_info[0].prior = 8'd1;  bus.req_data[0] = 64'h11;
    tick();
    bus.req_valid = '0;
    tick();
    bus.pq_ready = 1'b0;
    tick();
    check("mr_deq", 64'(bus.pq_deq_en), 64'd1);
    tick();
    check("mr_wait", 64'(dut.state), 64'(WAIT));
    rst = 1'b1;
    tick();
    check_zero("mr");
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, %0d/%0d so far", passed, total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pkt_prior_sched.md
# pkt_prior_sched

Scheduler in front of and behind `pkt_Priorer`. It round-robin arbitrates `NUM_REQ` ingress requesters onto the single priority-queue enqueue port. It tracks queue occupancy and sequences the queue between FILL and DRAIN phases, moving dequeued entries to a registered egress port with valid/ready back-pressure.

## Interface
- `NUM_REQ`, 4: number of ingress requesters (2..16).
- `DWIDTH`, 64: data/address width carried with each packet.
- `QDEPTH`, 16: priority-queue capacity; occupancy counter is `$clog2(QDEPTH+1)` bits.
- `DRAIN_BATCH`, 8: maximum entries dequeued per DRAIN phase (1..QDEPTH).
- `IDLE_TIMEOUT`, 16: idle FILL cycles with occupancy > 0 that force a DRAIN.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester packet valid.
- `req_ready` out NUM_REQ: one-hot accept; a handshake occurs on `req_valid[i] & req_ready[i]`.
- `req_info` in NUM_REQ x `pkHeadInfo`: header per requester.
- `req_data` in NUM_REQ x DWIDTH: data/address per requester.
- `pq_en` out 1: enqueue strobe to `pkt_Priorer.in_en`.
- `pq_ready` in 1: queue can accept, from `pkt_Priorer.in_valid`.
- `pq_info` out `pkHeadInfo`: enqueued header.
- `pq_data` out DWIDTH: enqueued data.
- `pq_deq_en` out 1: single-cycle dequeue pulse.
- `pq_out_valid` in 1: queue output valid.
- `pq_out_data` in DWIDTH: queue output data.
- `pq_out_prior` in PRIOR_WIDTH: queue output priority.
- `eg_valid` out 1: egress valid.
- `eg_ready` in 1: egress ready.
- `eg_data` out DWIDTH: egress data.
- `eg_prior` out PRIOR_WIDTH: egress priority.
- `grant_id` out `$clog2(NUM_REQ)`: index of the last accepted requester.
- `drain_active` out 1: high in DRAIN and WAIT.

## Operation

**States.** FILL (reset state), DRAIN, WAIT.

**FILL.**
- Arbitration is round-robin starting at `rr_ptr`; the lowest valid index at or after `rr_ptr` (with wrap) wins.
- `req_ready[win]` = `(!pq_en | pq_ready)` & !`full`, where `full` = (occupancy == QDEPTH).
- On handshake: register info/data into `pq_info`/`pq_data`, set `pq_en`, `grant_id` = win, `rr_ptr` = win+1 mod NUM_REQ.
- `pq_en` and the registered payload hold stable until `pq_en & pq_ready`. A transfer increments occupancy.

**FILL -> DRAIN.** Taken when any of the following holds, and only once `pq_en` is low (no pending enqueue):
- occupancy == QDEPTH, or
- `pq_ready` low with occupancy > 0, or
- the idle counter reaches IDLE_TIMEOUT. The idle counter counts cycles with no `req_valid`, saturates, and clears on any `req_valid` or on leaving FILL.

**DRAIN.**
- `req_ready` is all zero.
- Pulse `pq_deq_en` when no dequeue is outstanding, the egress register is empty or being consumed this cycle, and occupancy > 0. Then go to WAIT.
- A dequeue decrements occupancy and increments the batch counter.
- Leave DRAIN for FILL when the batch count == DRAIN_BATCH or occupancy == 0. The batch counter resets on entry to DRAIN.

**WAIT.**
- Hold until `pq_out_valid`, then capture `pq_out_data`/`pq_out_prior` into the egress register and set `eg_valid`.
- Return to DRAIN, or to FILL if the batch is done or occupancy == 0.

**Egress.** `eg_valid` holds with stable data until `eg_ready`.

**Width rule.** Occupancy never wraps. Enqueue at QDEPTH or dequeue at 0 is blocked by the rules above.

## Timing
- Ingress handshake at cycle N -> `pq_en` high at N+1. Back-to-back grants are possible at 1 per cycle while `pq_ready` stays high.
- `pq_deq_en` at cycle N -> the queue presents `pq_out_valid` at N+1 -> `eg_valid` at N+2. Drain throughput is 1 entry per 2 cycles.
- `pq_out_valid` outside WAIT is ignored.
- Reset values: `req_ready`=0, `pq_en`=0, `pq_info`=0, `pq_data`=0, `pq_deq_en`=0, `eg_valid`=0, `eg_data`=0, `eg_prior`=0, `grant_id`=0, `drain_active`=0, `rr_ptr`=0, occupancy=0, state=FILL.
- Reset mid-operation discards any pending enqueue, outstanding dequeue and egress entry. The team resets `pkt_Priorer` on the same `rst`.

## Structure
- Shared package `pkt_h`:
  - existing `pkHeadInfo` and `PRIOR_WIDTH`;
  - add enum `sched_state_e` {FILL, DRAIN, WAIT}.
- Sub-module `pkt_rr_arbiter` (parameter NUM_REQ): inputs `req`, `ptr`; outputs one-hot `gnt` and `gnt_idx`; purely combinational.
- Pointer, occupancy, FSM and egress register live in `pkt_prior_sched`.

## Test plan
- Round-robin: all 4 `req_valid` high, `pq_ready`=1 -> `grant_id` sequence 0,1,2,3,0 on consecutive cycles; `pq_en` high continuously from cycle 2.
- Back-pressure: `pq_ready` low with `pq_en` high and occupancy 3 -> `pq_info`/`pq_data` stable and `req_ready`=0; FSM enters DRAIN the cycle `pq_en` clears.
- Full: 16 enqueues with QDEPTH=16 -> state DRAIN; exactly 8 `pq_deq_en` pulses (DRAIN_BATCH=8), then FILL with occupancy 8.
- Idle drain: 3 enqueues, then no requests for 16 cycles -> DRAIN; 3 egress beats with the priorities driven by the queue; occupancy returns to 0.
- Egress stall: `eg_ready`=0 during DRAIN -> one `eg_valid` held stable and no further `pq_deq_en` until `eg_ready` rises.
- Reset mid-WAIT: assert `rst` one cycle after `pq_deq_en` -> next cycle all outputs 0, state FILL, occupancy 0.
